// File: rtl/common_split_buffer2.sv
// Two-way dispatch buffer: one valid/ready input is steered per beat into one of two
// independent 2-entry lane FIFOs. Optional broadcast: define COMMON_SPLIT_BUFFER2_BROADCAST_EN.

module common_split_buffer2_lane #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         push_i,
    input  logic         pop_rdy_i,
    input  logic [W-1:0] data_i,
    output logic         pushable_o,
    output logic         valid_o,
    output logic [W-1:0] data_o
);
    logic [1:0]        cnt_q, cnt_d;
    logic              wptr_q, rptr_q;
    logic [1:0][W-1:0] mem_q;
    logic              pop;

    assign pushable_o = (cnt_q != 2'd2);
    assign valid_o    = (cnt_q != 2'd0);
    assign data_o     = mem_q[rptr_q];
    assign pop        = valid_o && pop_rdy_i;
    // push_i is already gated by pushable_o upstream, so count stays within 0..2
    assign cnt_d      = cnt_q + {1'b0, push_i} - {1'b0, pop};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q  <= '0;
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
            mem_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (push_i) begin
                mem_q[wptr_q] <= data_i;
                wptr_q        <= ~wptr_q;
            end
            if (pop) rptr_q <= ~rptr_q;
        end
    end
endmodule

module common_split_buffer2 #(
    parameter int BUFFER_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [BUFFER_WIDTH-1:0] prev_i_data,
    input  logic                    prev_i_sel,
    input  logic                    prev_i_bcast,
    input  logic                    prev_i_valid,
    output logic                    prev_o_ready,
    output logic [BUFFER_WIDTH-1:0] next0_o_data,
    output logic                    next0_o_valid,
    input  logic                    next0_i_ready,
    output logic [BUFFER_WIDTH-1:0] next1_o_data,
    output logic                    next1_o_valid,
    input  logic                    next1_i_ready
);
    localparam int NUM_LANES = 2;

    logic [NUM_LANES-1:0]                   push, pushable, valid, rdy;
    logic [NUM_LANES-1:0][BUFFER_WIDTH-1:0] data;
    logic                                   accept;

    assign accept = prev_i_valid && prev_o_ready;

`ifdef COMMON_SPLIT_BUFFER2_BROADCAST_EN
    // Broadcast needs room in both lanes since the beat lands in each
    assign prev_o_ready = prev_i_bcast ? (pushable[0] && pushable[1]) : pushable[prev_i_sel];
    assign push[0]      = accept && (prev_i_bcast || !prev_i_sel);
    assign push[1]      = accept && (prev_i_bcast ||  prev_i_sel);
`else
    logic unused_bcast;
    assign unused_bcast = prev_i_bcast;
    assign prev_o_ready = pushable[prev_i_sel];
    assign push[0]      = accept && !prev_i_sel;
    assign push[1]      = accept &&  prev_i_sel;
`endif

    assign rdy = {next1_i_ready, next0_i_ready};

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        common_split_buffer2_lane #(.W(BUFFER_WIDTH)) u_lane (
            .clk        (clk),
            .resetn     (resetn),
            .push_i     (push[g]),
            .pop_rdy_i  (rdy[g]),
            .data_i     (prev_i_data),
            .pushable_o (pushable[g]),
            .valid_o    (valid[g]),
            .data_o     (data[g])
        );
    end

    assign next0_o_valid = valid[0];
    assign next1_o_valid = valid[1];
    assign next0_o_data  = data[0];
    assign next1_o_data  = data[1];
endmodule

// File: tb/tb_common_split_buffer2.sv
// Directed self-checking bench for common_split_buffer2: reset, steering, backpressure,
// full-lane retry, back-to-back streaming and broadcast (or its absence).
module tb_common_split_buffer2;
    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] data;
    logic        sel, bcast, valid, r0, r1;
    logic        rdy, v0, v1;
    logic [31:0] d0, d1;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    common_split_buffer2 #(.BUFFER_WIDTH(32)) dut (
        .clk(clk), .resetn(resetn),
        .prev_i_data(data), .prev_i_sel(sel), .prev_i_bcast(bcast), .prev_i_valid(valid),
        .prev_o_ready(rdy),
        .next0_o_data(d0), .next0_o_valid(v0), .next0_i_ready(r0),
        .next1_o_data(d1), .next1_o_valid(v1), .next1_i_ready(r1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vl, input logic s, input logic [31:0] d);
        valid = vl; sel = s; data = d;
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; data = '0; sel = 0; bcast = 0; valid = 0; r0 = 0; r1 = 0;
        #12;
        checks++; if (v0 !== 1'b0)   begin errors++; $display("FAIL rst_v0 got %0b exp 0", v0); end
        checks++; if (v1 !== 1'b0)   begin errors++; $display("FAIL rst_v1 got %0b exp 0", v1); end
        checks++; if (d0 !== 32'h0)  begin errors++; $display("FAIL rst_d0 got %h exp 0", d0); end
        checks++; if (d1 !== 32'h0)  begin errors++; $display("FAIL rst_d1 got %h exp 0", d1); end
        checks++; if (rdy !== 1'b1)  begin errors++; $display("FAIL rst_rdy got %0b exp 1", rdy); end
        resetn = 1'b1;
        step();
        // fill lane0 then reset mid-stream
        drive(1, 0, 32'hE1); step();
        drive(1, 0, 32'hE2); step();
        drive(0, 0, 32'h0);
        checks++; if (rdy !== 1'b0)  begin errors++; $display("FAIL mid_full_rdy got %0b exp 0", rdy); end
        checks++; if (d0 !== 32'hE1) begin errors++; $display("FAIL mid_full_d0 got %h exp e1", d0); end
        resetn = 1'b0;
        #1;
        checks++; if (v0 !== 1'b0)   begin errors++; $display("FAIL async_rst_v0 got %0b exp 0", v0); end
        checks++; if (d0 !== 32'h0)  begin errors++; $display("FAIL async_rst_d0 got %h exp 0", d0); end
        step(); step(); step();
        resetn = 1'b1;
        #1;
        checks++; if (v0 !== 1'b0 || v1 !== 1'b0) begin errors++; $display("FAIL post_rst_valid got %0b%0b exp 00", v1, v0); end
        checks++; if (d0 !== 32'h0 || d1 !== 32'h0) begin errors++; $display("FAIL post_rst_data got %h %h exp 0 0", d0, d1); end
        checks++; if (rdy !== 1'b1)  begin errors++; $display("FAIL post_rst_rdy got %0b exp 1", rdy); end
        // first accept on first edge after release
        drive(1, 1, 32'h55); step();
        checks++; if (v1 !== 1'b1 || d1 !== 32'h55) begin errors++; $display("FAIL first_acc got v%0b %h exp v1 55", v1, d1); end
        drive(0, 0, 32'h0); r1 = 1; step();
        checks++; if (v1 !== 1'b0)   begin errors++; $display("FAIL first_pop_v1 got %0b exp 0", v1); end
    endtask

    task automatic test_steering();
        r0 = 1; r1 = 1;
        drive(1, 0, 32'h11);
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL steer_rdy got %0b exp 1", rdy); end
        step();
        checks++; if (v0 !== 1'b1 || d0 !== 32'h11 || v1 !== 1'b0) begin errors++; $display("FAIL steer_11 got v%0b %h v1 %0b exp v1 11 v1 0", v0, d0, v1); end
        drive(1, 1, 32'h22); step();
        checks++; if (v1 !== 1'b1 || d1 !== 32'h22 || v0 !== 1'b0) begin errors++; $display("FAIL steer_22 got v%0b %h v0 %0b exp v1 22 v0 0", v1, d1, v0); end
        drive(1, 0, 32'h33); step();
        checks++; if (v0 !== 1'b1 || d0 !== 32'h33 || v1 !== 1'b0) begin errors++; $display("FAIL steer_33 got v%0b %h v1 %0b exp v1 33 v1 0", v0, d0, v1); end
        drive(0, 0, 32'h0); step();
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL steer_drain got %0b exp 0", v0); end
    endtask

    task automatic test_backpressure();
        r0 = 0; r1 = 1;
        drive(1, 0, 32'hA0); step();
        drive(1, 1, 32'hB0);
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL bp_b0_rdy got %0b exp 1", rdy); end
        step();
        drive(1, 0, 32'hA1);
        checks++; if (v1 !== 1'b1 || d1 !== 32'hB0) begin errors++; $display("FAIL bp_b0_out got v%0b %h exp v1 b0", v1, d1); end
        step();
        drive(1, 1, 32'hA2);
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL bp_sel1_rdy got %0b exp 1", rdy); end
        drive(1, 0, 32'hA2);
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL bp_full_rdy got %0b exp 0", rdy); end
        step();
        checks++; if (v0 !== 1'b1 || d0 !== 32'hA0) begin errors++; $display("FAIL bp_hold got v%0b %h exp v1 a0", v0, d0); end
        r0 = 1; #1;
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL bp_pop_rdy got %0b exp 0", rdy); end
        step();
        checks++; if (rdy !== 1'b1 || d0 !== 32'hA1) begin errors++; $display("FAIL bp_refill got rdy %0b %h exp 1 a1", rdy, d0); end
        step();
        drive(0, 0, 32'h0);
        checks++; if (v0 !== 1'b1 || d0 !== 32'hA2) begin errors++; $display("FAIL bp_a2 got v%0b %h exp v1 a2", v0, d0); end
        step();
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL bp_drain got %0b exp 0", v0); end
    endtask

    task automatic test_full_edge();
        r1 = 0;
        drive(1, 1, 32'hC0); step();
        drive(1, 1, 32'hC1); step();
        r1 = 1;
        drive(1, 1, 32'hC2);
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL fe_reject got %0b exp 0", rdy); end
        step();
        checks++; if (rdy !== 1'b1 || d1 !== 32'hC1) begin errors++; $display("FAIL fe_retry got rdy %0b %h exp 1 c1", rdy, d1); end
        step();
        drive(0, 0, 32'h0);
        checks++; if (v1 !== 1'b1 || d1 !== 32'hC2) begin errors++; $display("FAIL fe_c2 got v%0b %h exp v1 c2", v1, d1); end
        step();
        checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL fe_drain got %0b exp 0", v1); end
    endtask

    task automatic test_back_to_back();
        r0 = 1; r1 = 1;
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, 32'h100 + i);
            checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL b2b_rdy[%0d] got %0b exp 1", i, rdy); end
            if (i > 0) begin
                checks++;
                if (v1 !== 1'b1 || d1 !== 32'h100 + i - 1) begin errors++; $display("FAIL b2b_data[%0d] got v%0b %h exp v1 %h", i, v1, d1, 32'h100 + i - 1); end
            end
            step();
        end
        drive(0, 0, 32'h0);
        checks++; if (v1 !== 1'b1 || d1 !== 32'h10F || v0 !== 1'b0) begin errors++; $display("FAIL b2b_last got v%0b %h v0 %0b exp v1 10f v0 0", v1, d1, v0); end
        step();
        checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0b exp 0", v1); end
    endtask

    task automatic test_bcast();
        r0 = 1; r1 = 0; bcast = 0;
        drive(1, 1, 32'hD0); step();
        drive(1, 1, 32'hD1); step();
        bcast = 1;
`ifdef COMMON_SPLIT_BUFFER2_BROADCAST_EN
        drive(1, 0, 32'hCAFE);
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL bc_block got %0b exp 0", rdy); end
        r1 = 1; #1;
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL bc_block_pop got %0b exp 0", rdy); end
        step();
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL bc_open got %0b exp 1", rdy); end
        step();
        drive(0, 0, 32'h0); bcast = 0;
        checks++; if (v0 !== 1'b1 || d0 !== 32'hCAFE) begin errors++; $display("FAIL bc_l0 got v%0b %h exp v1 cafe", v0, d0); end
        checks++; if (v1 !== 1'b1 || d1 !== 32'hCAFE) begin errors++; $display("FAIL bc_l1 got v%0b %h exp v1 cafe", v1, d1); end
        step();
        checks++; if (v0 !== 1'b0 || v1 !== 1'b0) begin errors++; $display("FAIL bc_drain got %0b%0b exp 00", v1, v0); end
`else
        drive(1, 0, 32'hCAFE);
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL nobc_rdy got %0b exp 1", rdy); end
        step();
        drive(0, 0, 32'h0); bcast = 0;
        checks++; if (v0 !== 1'b1 || d0 !== 32'hCAFE) begin errors++; $display("FAIL nobc_l0 got v%0b %h exp v1 cafe", v0, d0); end
        checks++; if (d1 !== 32'hD0) begin errors++; $display("FAIL nobc_l1 got %h exp d0", d1); end
        r1 = 1; step();
        checks++; if (v0 !== 1'b0 || d1 !== 32'hD1) begin errors++; $display("FAIL nobc_pop got v0 %0b %h exp 0 d1", v0, d1); end
        step();
        checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL nobc_drain got %0b exp 0", v1); end
`endif
    endtask

    initial begin
        test_reset();
        test_steering();
        test_backpressure();
        test_full_edge();
        test_back_to_back();
        test_bcast();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
